lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store unit memory controller. It sits between the execute stage and data memory, and it is the producer of ls_rd_data for the writeback stage. It accepts one load/store request at a time and drives data memory through a valid/ready request channel and a valid-only response channel. For loads it extracts, aligns and sign/zero-extends the result to 64 bits; for stores it generates the byte mask and shifted write data.

Parameters:
ADDR_W, 64, request address width
DATA_W, 64, data width; fixed at 64, memory bus is 8-byte-wide aligned

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  execute-stage request valid
req_ready  output  1  unit can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  64  byte address
req_wdata  input  64  store data, right-justified
req_size  input  2  0=byte, 1=half, 2=word, 3=dword
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_addr  output  64  {req_addr[63:3], 3'b000}
mem_we  output  1  memory write enable
mem_wdata  output  64  store data shifted to byte lane
mem_wmask  output  8  byte-enable mask
mem_rsp_valid  input  1  memory response valid, single cycle
mem_rdata  input  64  aligned 8-byte read data
ls_rd_data  output  64  extended load result for writeback
ls_done  output  1  one-cycle pulse: access complete
ls_err  output  1  misaligned-access flag, valid when ls_done=1

Behaviour:
- States: IDLE, REQ, RESP, DONE. All outputs are registered or decoded from state and captured fields.
- Reset (rst=1 at edge): state=IDLE. Captured fields, ls_rd_data, ls_err and ls_done all go to 0. This applies in any state; an in-flight memory transaction is abandoned, and mem_req_valid is 0 from the following cycle.
- IDLE: req_ready=1, mem_req_valid=0. On req_valid=1, capture we/addr/wdata/size/unsigned.
  - Alignment is required as follows: size1 needs addr[0]=0, size2 needs addr[1:0]=0, size3 needs addr[2:0]=0.
  - Misaligned request: go to DONE with ls_err=1 and ls_rd_data=0. No memory request is issued.
  - Aligned request: go to REQ with ls_err=0.
- REQ: req_ready=0, mem_req_valid=1. mem_addr, mem_we, mem_wdata and mem_wmask are held stable until mem_req_ready=1, then go to RESP. mem_rsp_valid is ignored in REQ; memory never responds in its accept cycle.
- RESP: mem_req_valid=0. Wait indefinitely for mem_rsp_valid=1, then go to DONE.
  - Load: ls_rd_data is loaded with the extracted field: byte lane off=addr[2:0], field = mem_rdata >> (off*8), truncated to size, then sign- or zero-extended to 64.
  - Store: ls_rd_data=0.
- DONE: ls_done=1 for exactly one cycle, then go to IDLE. ls_rd_data and ls_err hold their values until the next capture.
- Store lane generation:
  - mem_wmask = base << off, where base is 0x01/0x03/0x0F/0xFF for size 0/1/2/3.
  - mem_wdata = (req_wdata with bits above size cleared) << (off*8).
- Loads drive mem_wmask=0 and mem_wdata=0.
- Minimum latency with ready and response both immediate: accept at edge T, REQ at T+1, RESP at T+2, DONE at T+3 (ls_done high in T+3). So a request is accepted every 4 cycles at best.
- A misaligned request completes in 2 cycles: IDLE, then DONE.
- Only one outstanding request is allowed; req_ready=0 outside IDLE.

Test Plan:
- Reset mid-RESP: issue load, assert rst in RESP, then deliver mem_rsp_valid -> state IDLE, ls_done never pulses, ls_rd_data=0, req_ready=1 next cycle.
- Signed byte load: addr=0x8000_0005, size=0, unsigned=0, mem_rdata=0x0000_8000_0000_0000 -> ls_rd_data=0xFFFF_FFFF_FFFF_FF80, ls_err=0, ls_done at T+3.
- Unsigned word load: addr=0x8000_0004, size=2, unsigned=1, mem_rdata=0xDEAD_BEEF_1234_5678 -> ls_rd_data=0x0000_0000_DEAD_BEEF.
- Half store with backpressure: addr=0x8000_0006, size=1, wdata=0xAAAA_BBBB_CCCC_1234, mem_req_ready held 0 for 3 cycles -> mem_addr=0x8000_0000, mem_wmask=0xC0, mem_wdata=0x1234_0000_0000_0000, all stable for 4 cycles; after the response, ls_rd_data=0.
- Misaligned dword: addr=0x8000_0004, size=3 -> mem_req_valid stays 0, ls_done and ls_err both 1 in the cycle after accept, ls_rd_data=0.
- Back-to-back: a load immediately followed by a store with req_valid held high -> second request accepted only in the IDLE cycle after ls_done, and no request is lost or duplicated.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store unit in front of an 8-byte-wide data memory.
// Loads are lane-extracted and extended; stores get a byte mask and lane-shifted data.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ls_rd_data,
    output logic              ls_done,
    output logic              ls_err
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    state_t            r_state;
    logic              r_we;
    logic              r_uns;
    logic              r_err;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rd_data;
    logic              w_mis;
    logic [2:0]        w_off;
    logic [5:0]        w_sh;
    logic [7:0]        w_base;
    logic [DATA_W-1:0] w_dmask;
    logic [DATA_W-1:0] w_fld;
    logic [DATA_W-1:0] w_ld;

    // low address bits that must be zero: none/0/1:0/2:0 for byte/half/word/dword
    assign w_mis   = |(req_addr[2:0] & {&req_size, req_size[1], |req_size});
    assign w_off   = r_addr[2:0];
    assign w_sh    = {w_off, 3'b000};
    assign w_base  = r_size == 2'd0 ? 8'h01 : r_size == 2'd1 ? 8'h03 : r_size == 2'd2 ? 8'h0F : 8'hFF;
    assign w_dmask = r_size == 2'd0 ? 64'hFF : r_size == 2'd1 ? 64'hFFFF :
                     r_size == 2'd2 ? 64'hFFFF_FFFF : {DATA_W{1'b1}};
    assign w_fld   = mem_rdata >> w_sh;
    assign w_ld    = r_size == 2'd0 ? {{56{~r_uns & w_fld[7]}}, w_fld[7:0]} :
                     r_size == 2'd1 ? {{48{~r_uns & w_fld[15]}}, w_fld[15:0]} :
                     r_size == 2'd2 ? {{32{~r_uns & w_fld[31]}}, w_fld[31:0]} : w_fld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_uns     <= 1'b0;
            r_err     <= 1'b0;
            r_size    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd_data <= '0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_we      <= req_we;
                    r_uns     <= req_unsigned;
                    r_size    <= req_size;
                    r_addr    <= req_addr;
                    r_wdata   <= req_wdata;
                    r_rd_data <= '0;
                    r_err     <= w_mis;
                    r_state   <= w_mis ? DONE : REQ;
                end
                REQ:  if (mem_req_ready) r_state <= RESP;
                RESP: if (mem_rsp_valid) begin
                    r_rd_data <= r_we ? '0 : w_ld;
                    r_state   <= DONE;
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready     = r_state == IDLE;
    assign mem_req_valid = r_state == REQ;
    assign ls_done       = r_state == DONE;
    assign ls_err        = r_err;
    assign ls_rd_data    = r_rd_data;
    assign mem_addr      = {r_addr[ADDR_W-1:3], 3'b000};
    assign mem_we        = r_we;
    assign mem_wmask     = r_we ? w_base << w_off : 8'h00;
    assign mem_wdata     = r_we ? (r_wdata & w_dmask) << w_sh : '0;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed and randomized transactions checked against an arithmetic model.
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic [63:0] ls_rd_data;
    logic        ls_done;
    logic        ls_err;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] prev_rd = '0;

    always #5 clk = ~clk;

    lsu_mem_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata), .ls_rd_data(ls_rd_data), .ls_done(ls_done), .ls_err(ls_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fmask(input logic [1:0] sz);
        int nb = 8 << sz;
        return nb == 64 ? '1 : (64'd1 << nb) - 64'd1;
    endfunction

    function automatic logic [63:0] ld_model(input logic [63:0] d, input logic [2:0] off,
                                             input logic [1:0] sz, input logic u);
        int nb = 8 << sz;
        logic [63:0] v = (d >> (int'(off) * 8)) & fmask(sz);
        if (!u && v[nb-1]) v = v | ~fmask(sz);
        return v;
    endfunction

    // one request, starting from the DONE or IDLE negedge; ends at the negedge showing DONE
    task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [1:0] sz, input logic u, input int rdly, input int sdly,
                       input logic [63:0] rdata);
        logic [2:0]  off = addr[2:0];
        logic        mis = (int'(addr[2:0]) % (1 << sz)) != 0;
        logic [63:0] e_addr = addr & ~64'h7;
        logic [7:0]  e_mask = we ? 8'(((16'd1 << (1 << sz)) - 16'd1) << off) : 8'h00;
        logic [63:0] e_wd = we ? (wdata & fmask(sz)) << (int'(off) * 8) : 64'h0;
        logic [63:0] e_rd = (we || mis) ? 64'h0 : ld_model(rdata, off, sz, u);
        @(negedge clk);
        chk("idle_ready", {63'h0, req_ready}, 64'h1);
        chk("idle_done", {63'h0, ls_done}, 64'h0);
        chk("hold_rd", ls_rd_data, prev_rd);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = sz; req_unsigned = u;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
        if (mis) begin
            chk("mis_done", {63'h0, ls_done}, 64'h1);
            chk("mis_err", {63'h0, ls_err}, 64'h1);
            chk("mis_memv", {63'h0, mem_req_valid}, 64'h0);
            chk("mis_rd", ls_rd_data, 64'h0);
            prev_rd = 64'h0;
            return;
        end
        for (int i = 0; i <= rdly; i++) begin
            chk("req_valid", {63'h0, mem_req_valid}, 64'h1);
            chk("req_rdy", {63'h0, req_ready}, 64'h0);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_we", {63'h0, mem_we}, {63'h0, we});
            chk("mem_wmask", {56'h0, mem_wmask}, {56'h0, e_mask});
            chk("mem_wdata", mem_wdata, e_wd);
            mem_req_ready = (i == rdly);
            mem_rsp_valid = (i == rdly) ? 1'b0 : 1'($urandom);
            mem_rdata = {$urandom, $urandom};
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < sdly; i++) begin
            chk("resp_memv", {63'h0, mem_req_valid}, 64'h0);
            chk("resp_done", {63'h0, ls_done}, 64'h0);
            @(negedge clk);
        end
        chk("resp_memv", {63'h0, mem_req_valid}, 64'h0);
        mem_rsp_valid = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rdata = {$urandom, $urandom};
        chk("done", {63'h0, ls_done}, 64'h1);
        chk("err", {63'h0, ls_err}, 64'h0);
        chk("rd_data", ls_rd_data, e_rd);
        prev_rd = e_rd;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", {63'h0, req_ready}, 64'h1);
        chk("rst_memv", {63'h0, mem_req_valid}, 64'h0);
        chk("rst_done", {63'h0, ls_done}, 64'h0);
        chk("rst_err", {63'h0, ls_err}, 64'h0);
        chk("rst_rd", ls_rd_data, 64'h0);
        rst = 1'b0;
        txn(1'b0, 64'h8000_0005, 64'h0, 2'd0, 1'b0, 0, 0, 64'h0000_8000_0000_0000);
        chk("sbyte", ls_rd_data, 64'hFFFF_FFFF_FFFF_FF80);
        txn(1'b0, 64'h8000_0004, 64'h0, 2'd2, 1'b1, 0, 1, 64'hDEAD_BEEF_1234_5678);
        chk("uword", ls_rd_data, 64'h0000_0000_DEAD_BEEF);
        txn(1'b1, 64'h8000_0006, 64'hAAAA_BBBB_CCCC_1234, 2'd1, 1'b0, 3, 2, 64'hFFFF_FFFF_FFFF_FFFF);
        txn(1'b0, 64'h8000_0004, 64'h0, 2'd3, 1'b0, 0, 0, 64'h0);
        // load then store with req_valid already high during the load's DONE cycle
        txn(1'b0, 64'h8000_0010, 64'h0, 2'd3, 1'b0, 1, 0, 64'h0123_4567_89AB_CDEF);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h8000_0013; req_size = 2'd0;
        txn(1'b1, 64'h8000_0013, 64'h55, 2'd0, 1'b0, 0, 0, 64'h0);
        repeat (2) begin
            @(negedge clk);
            chk("no_dup", {63'h0, mem_req_valid}, 64'h0);
        end
        // reset while waiting for the response
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h8000_0008; req_size = 2'd3;
        @(negedge clk);
        req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
        chk("rr_ready", {63'h0, req_ready}, 64'h1);
        chk("rr_rd", ls_rd_data, 64'h0);
        chk("rr_done", {63'h0, ls_done}, 64'h0);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("rr_done2", {63'h0, ls_done}, 64'h0);
        chk("rr_memv", {63'h0, mem_req_valid}, 64'h0);
        chk("rr_rd2", ls_rd_data, 64'h0);
        prev_rd = 64'h0;
        repeat (300) begin
            txn(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom),
                1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                {$urandom, $urandom});
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
